// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffer entry layout
// and the canonical NOP encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer; slot0 is always the head.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_entry;
                    else               slot1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new entry lands behind whatever remains.
                    if (count == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head       = slot0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requester feeding a 2-entry buffer.
// Optional FETCH_STATS_EN adds a 32-bit fetch_count of consumed instructions.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned oplen    = 7,
    parameter int unsigned DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    output logic [31:0]      imem_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic [oplen-1:0] op,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      fetch_count
`endif
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic [1:0]   count;
    logic [1:0]   count_after;
    logic         push;
    logic         pop;
    logic         outstanding_after;
    fetch_entry_t head;

    assign pop  = inst_valid && inst_ready;
    assign push = imem_rsp_valid && (state == WAIT) && !redirect_valid;
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    // A request is still in flight past this edge unless its response lands now.
    assign outstanding_after = (((state == WAIT) || (state == DROP)) && !imem_rsp_valid)
                             || ((state == REQ) && imem_req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            req_pc         <= '0;
            imem_req_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (outstanding_after) begin
                state          <= DROP;
                imem_req_valid <= 1'b0;
            end else begin
                state          <= REQ;
                imem_req_valid <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        req_pc         <= pc;
                        pc             <= pc + 32'd4;
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (count_after < DEPTH_C) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            state          <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem_addr = pc;

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry ('{pc: req_pc, inst: imem_rsp_data}),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (inst_valid),
        .head       (head)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;
    assign op      = oplen'(head.inst[6:0]);
    assign funct3  = head.inst[14:12];
    assign funct7  = head.inst[31:25];

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: program-order model of fetched words against a
// behavioural instruction memory; directed scenarios followed by a randomized run.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(RESET_PC),
        .oplen   (7),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural instruction memory ----------------
    bit          special_en = 1'b0;
    logic [31:0] special_addr = 32'h4;
    logic [31:0] special_word = 32'h4020_80B3;
    bit          spurious_en = 1'b0;
    int unsigned lat_lo = 0;
    int unsigned lat_hi = 0;

    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int unsigned pend_wait = 0;
    bit          hs_last = 1'b0;
    bit          rsp_last = 1'b0;
    logic [31:0] addr_last = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (special_en && (a == special_addr)) return special_word;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: update memory from the last edge, then drive this cycle's inputs.
    task automatic step(input bit rdy, input bit ird, input bit redir, input logic [31:0] rpc);
        @(posedge clk);
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (rsp_last) pend = 1'b0;
            if (hs_last) begin
                pend      = 1'b1;
                pend_addr = addr_last;
                pend_wait = $urandom_range(lat_hi, lat_lo);
            end
        end
        #1;
        imem_rsp_valid = 1'b0;
        if (pend && rst_n) begin
            if (pend_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
            end else begin
                pend_wait--;
            end
        end else if (spurious_en && rst_n && ($urandom_range(0, 7) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = rdy;
        inst_ready     = ird;
        redirect_valid = redir;
        redirect_pc    = rpc;
        hs_last   = rst_n && imem_req_valid && imem_req_ready;
        addr_last = imem_addr;
        rsp_last  = rst_n && imem_rsp_valid;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] exp_q[$];
    bit          out_v = 1'b0;
    bit          out_taint = 1'b0;
    logic [31:0] out_addr = '0;
    logic [31:0] exp_req_pc = RESET_PC;
    int unsigned pops = 0;

    always @(negedge clk) begin : mon
        logic [63:0] e;
        int unsigned occ0;
        if (!rst_n) begin
            exp_q.delete();
            out_v      = 1'b0;
            out_taint  = 1'b0;
            exp_req_pc = RESET_PC;
            pops       = 0;
        end else begin
            occ0 = exp_q.size();
            check("inst_valid_vs_model", inst_valid, occ0 != 0);
`ifdef FETCH_STATS_EN
            check("fetch_count", fetch_count, pops);
`endif
            if (inst_valid && inst_ready && (exp_q.size() != 0)) begin
                e = exp_q.pop_front();
                check("pop_pc", inst_pc, e[63:32]);
                check("pop_inst", inst, e[31:0]);
                check("pop_op", op, e[6:0]);
                check("pop_funct3", funct3, e[14:12]);
                check("pop_funct7", funct7, e[31:25]);
                pops++;
            end
            if (imem_rsp_valid && out_v) begin
                if (!out_taint && !redirect_valid) exp_q.push_back({out_addr, mem_word(out_addr)});
                out_v = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_addr, exp_req_pc);
                check("req_single_outstanding", out_v, 1'b0);
                check("req_buffer_room", occ0 < 2, 1'b1);
                out_v      = 1'b1;
                out_taint  = 1'b0;
                out_addr   = exp_req_pc;
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                out_taint  = 1'b1;
                exp_req_pc = redirect_pc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          found;
        bit          saw_stale;
        logic [31:0] r;

        special_en = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_op", op, 7'h0);
        check("rst_funct3", funct3, 3'h0);
        check("rst_funct7", funct7, 7'h0);
        check("rst_addr", imem_addr, RESET_PC);

        // Release and first-request timing, then sequential fetch with a known word at 0x4.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req_cycle1", imem_req_valid, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("first_req_cycle2", imem_req_valid, 1'b1);
        check("first_req_addr", imem_addr, RESET_PC);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_rsp_valid && (pend_addr == 32'h4)) begin
                found = 1'b1;
                break;
            end
        end
        check("rsp_at_4_seen", found, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("decode_valid", inst_valid, 1'b1);
        check("decode_pc", inst_pc, 32'h4);
        check("decode_op", op, 7'b0110011);
        check("decode_funct3", funct3, 3'b000);
        check("decode_funct7", funct7, 7'b0100000);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Back-pressure: buffer fills to two entries and fetching stops.
        do_reset();
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("full_req_valid", imem_req_valid, 1'b0);
        check("full_inst_valid", inst_valid, 1'b1);
        check("full_head_pc", inst_pc, RESET_PC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("drain1_valid", inst_valid, 1'b1);
        check("drain1_pc", inst_pc, RESET_PC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("drain2_valid", inst_valid, 1'b1);
        check("drain2_pc", inst_pc, RESET_PC + 32'd4);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("drain3_empty", inst_valid, 1'b0);
        check("drain3_refetch", imem_req_valid, 1'b1);

        // Redirect while a request is outstanding: stale response must be dropped.
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (pend && !imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_reached", found, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        found     = 1'b0;
        saw_stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_rsp_valid) saw_stale = 1'b1;
            @(negedge clk);
            check("redir_no_stale_valid", inst_valid, 1'b0);
            if (imem_req_valid && imem_req_ready) begin
                check("redir_req_addr", imem_addr, 32'h100);
                found = 1'b1;
                break;
            end
        end
        check("redir_req_seen", found, 1'b1);
        check("redir_stale_rsp_seen", saw_stale, 1'b1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coincident with a response.
        do_reset();
        lat_lo = 0;
        lat_hi = 0;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("coinc_rsp_seen", found, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("coinc_inst_valid", inst_valid, 1'b0);
        check("coinc_req_valid", imem_req_valid, 1'b1);
        check("coinc_req_addr", imem_addr, 32'h200);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset asserted mid-transaction.
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (pend && !imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_wait_reached", found, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req_valid", imem_req_valid, 1'b0);
        check("midrst_inst_valid", inst_valid, 1'b0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        check("midrst_addr", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n  = 1'b1;
        lat_lo = 0;
        lat_hi = 0;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            if (inst_valid) begin
                check("midrst_first_pc", inst_pc, RESET_PC);
                found = 1'b1;
                break;
            end
        end
        check("midrst_fetch_resumed", found, 1'b1);

        // Randomized traffic with redirects and spurious response beats.
        do_reset();
        lat_lo      = 0;
        lat_hi      = 2;
        spurious_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, r & 32'hFFFF_FFFC);
        end
        spurious_en = 1'b0;
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
